// File: rtl/m_dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// Holds arbiter state encoding, port indices and default limits.
package m_dmem_arb_pkg;

    typedef enum logic {
        ST_FREE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int MAX_WAIT_DEF  = 4;
    localparam int BURST_MAX_DEF = 8;

endpackage

// File: rtl/m_arb_rdret.sv
// Read-return tracker: remembers which port issued a read last cycle.
// Ports: w_rd_gnt/w_rd_port in, w_m_rdata in, per-port rvalid/rdata out.
module m_arb_rdret
    import m_dmem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          w_rd_gnt,
    input  logic          w_rd_port,
    input  logic [DW-1:0] w_m_rdata,
    output logic          w_c_rvalid,
    output logic [DW-1:0] w_c_rdata,
    output logic          w_d_rvalid,
    output logic [DW-1:0] w_d_rdata
);

    logic r_pend;
    logic r_port;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pend <= 1'b0;
            r_port <= PORT_C;
        end else begin
            r_pend <= w_rd_gnt;
            r_port <= w_rd_port;
        end
    end

    assign w_c_rvalid = r_pend & (r_port == PORT_C);
    assign w_d_rvalid = r_pend & (r_port == PORT_D);
    assign w_c_rdata  = w_c_rvalid ? w_m_rdata : '0;
    assign w_d_rdata  = w_d_rvalid ? w_m_rdata : '0;

endmodule

// File: rtl/m_dmem_arb.sv
// Two-port arbiter for the shared data memory: C has priority, D bursts.
// Ports: C/D request sides, memory side w_m_*, stall, per-port read return.
module m_dmem_arb
    import m_dmem_arb_pkg::*;
#(
    parameter int AW        = 11,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = MAX_WAIT_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic          w_clk,
    input  logic          w_rst_n,
    input  logic          w_c_req,
    input  logic          w_c_we,
    input  logic [AW-1:0] w_c_addr,
    input  logic [DW-1:0] w_c_wdata,
    output logic          w_c_gnt,
    output logic          w_c_stall,
    output logic          w_c_rvalid,
    output logic [DW-1:0] w_c_rdata,
    input  logic          w_d_req,
    input  logic          w_d_we,
    input  logic          w_d_lock,
    input  logic [AW-1:0] w_d_addr,
    input  logic [DW-1:0] w_d_wdata,
    output logic          w_d_gnt,
    output logic          w_d_rvalid,
    output logic [DW-1:0] w_d_rdata,
    output logic [AW-1:0] w_m_addr,
    output logic          w_m_we,
    output logic [DW-1:0] w_m_wdata,
    input  logic [DW-1:0] w_m_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(BURST_MAX + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BMAX = BW'(BURST_MAX);
    localparam bit BURST_EN = (BURST_MAX > 1);

    arb_state_e    state;
    arb_state_e    state_nx;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nx;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_nx;
    logic [BW-1:0] burst_inc;
    logic          d_force;
    logic          rd_gnt;
    logic          rd_port;

    assign burst_inc = burst_cnt + BW'(1);
    // Starvation override: D wins outright once it has waited MAX_WAIT cycles.
    assign d_force   = w_d_req & (wait_cnt == WMAX);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state     <= ST_FREE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            burst_cnt <= burst_nx;
        end
    end

    always_comb begin
        w_c_gnt  = 1'b0;
        w_d_gnt  = 1'b0;
        state_nx = state;
        burst_nx = burst_cnt;
        unique case (state)
            ST_FREE: begin
                if (d_force) begin
                    w_d_gnt = 1'b1;
                end else if (w_c_req) begin
                    w_c_gnt = 1'b1;
                end else if (w_d_req) begin
                    w_d_gnt = 1'b1;
                end
                if (w_d_gnt && w_d_lock && BURST_EN) begin
                    state_nx = ST_BURST;
                    burst_nx = BW'(1);
                end
            end
            ST_BURST: begin
                if (w_d_req) begin
                    w_d_gnt = 1'b1;
                    if (w_d_lock && (burst_inc < BMAX)) begin
                        burst_nx = burst_inc;
                    end else begin
                        state_nx = ST_FREE;
                        burst_nx = '0;
                    end
                end else begin
                    // D released the bus early; C may take this same cycle.
                    w_c_gnt  = w_c_req;
                    state_nx = ST_FREE;
                    burst_nx = '0;
                end
            end
            default: begin
                state_nx = ST_FREE;
                burst_nx = '0;
            end
        endcase
    end

    always_comb begin
        wait_nx = '0;
        if (w_d_req && !w_d_gnt) begin
            wait_nx = (wait_cnt == WMAX) ? WMAX : wait_cnt + WW'(1);
        end
    end

    always_comb begin
        w_m_addr  = '0;
        w_m_we    = 1'b0;
        w_m_wdata = '0;
        unique case (1'b1)
            w_c_gnt: begin
                w_m_addr  = w_c_addr;
                w_m_we    = w_c_we;
                w_m_wdata = w_c_wdata;
            end
            w_d_gnt: begin
                w_m_addr  = w_d_addr;
                w_m_we    = w_d_we;
                w_m_wdata = w_d_wdata;
            end
            default: ;
        endcase
    end

    assign w_c_stall = w_c_req & ~w_c_gnt;
    assign rd_gnt    = (w_c_gnt | w_d_gnt) & ~w_m_we;
    assign rd_port   = w_d_gnt ? PORT_D : PORT_C;

    m_arb_rdret #(
        .DW (DW)
    ) u_rdret (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_rd_gnt   (rd_gnt),
        .w_rd_port  (rd_port),
        .w_m_rdata  (w_m_rdata),
        .w_c_rvalid (w_c_rvalid),
        .w_c_rdata  (w_c_rdata),
        .w_d_rvalid (w_d_rvalid),
        .w_d_rdata  (w_d_rdata)
    );

endmodule

// File: doc/m_dmem_arb.md
Name: m_dmem_arb

Overview:
- Two-requester arbiter and sequencer for the shared single-port data memory (2K x 32, synchronous read, 1-cycle latency, write-first-cycle returns old data).
- Requester C is the processor MEM stage; requester D is a debug/DMA/loader engine that may issue locked bursts.
- C has priority, but D gets a bounded-starvation guarantee.
- Grants are same-cycle. Read data returns one cycle later with a per-port valid. The arbiter raises a stall to the pipeline whenever C is denied.

Parameters:
AW, 11, word-address width (memory is 2^AW words)
DW, 32, data width
MAX_WAIT, 4, consecutive denied cycles after which D is force-granted (>=1)
BURST_MAX, 8, maximum beats in one locked D burst (>=1)

Ports:
w_clk  in  1  clock, rising edge
w_rst_n  in  1  asynchronous active-low reset
w_c_req  in  1  C access request, held until granted
w_c_we  in  1  C write enable (0 = read)
w_c_addr  in  AW  C word address
w_c_wdata  in  DW  C write data
w_c_gnt  out  1  C granted this cycle (combinational)
w_c_stall  out  1  w_c_req & ~w_c_gnt; freezes IF..MEM
w_c_rvalid  out  1  C read data valid (registered)
w_c_rdata  out  DW  C read data
w_d_req  in  1  D access request
w_d_we  in  1  D write enable
w_d_lock  in  1  D requests the next beat stay in the burst
w_d_addr  in  AW  D word address
w_d_wdata  in  DW  D write data
w_d_gnt  out  1  D granted this cycle (combinational)
w_d_rvalid  out  1  D read data valid (registered)
w_d_rdata  out  DW  D read data
w_m_addr  out  AW  memory address
w_m_we  out  1  memory write enable
w_m_wdata  out  DW  memory write data
w_m_rdata  in  DW  memory registered read output

Behaviour:
- Reset (asynchronous, takes effect immediately on w_rst_n low):
  - state = ST_FREE; wait_cnt = 0; burst_cnt = 0; both rvalid = 0.
  - Any read in flight is discarded; no rvalid follows reset release.
- Grant rules:
  - At most one grant per cycle.
  - The granted port's addr/we/wdata drive w_m_*.
  - With no grant: w_m_we = 0, w_m_addr = 0, w_m_wdata = 0.
- ST_FREE:
  - If d_req and wait_cnt == MAX_WAIT, grant D (starvation override, even if c_req).
  - Else if c_req, grant C.
  - Else if d_req, grant D.
  - If D is granted with d_lock = 1 and BURST_MAX > 1: next state ST_BURST, burst_cnt <= 1.
- ST_BURST (D owns the memory):
  - If d_req, grant D and burst_cnt <= burst_cnt + 1. Stay in ST_BURST only if d_lock = 1 and burst_cnt + 1 < BURST_MAX; otherwise return to ST_FREE, burst_cnt <= 0.
  - If d_req = 0, the burst ends: grant C if c_req, return to ST_FREE, burst_cnt <= 0.
  - C stalls throughout a burst. The burst ceiling bounds the stall to BURST_MAX cycles.
- wait_cnt:
  - Increments each cycle with d_req & ~d_gnt, saturating at MAX_WAIT.
  - Clears to 0 when d_gnt or ~d_req.
- Read return:
  - A granted read (we = 0) in cycle N sets that port's rvalid in cycle N+1.
  - In that cycle, rdata = w_m_rdata; otherwise rdata = 0.
  - Writes never raise rvalid.
  - Back-to-back reads to alternating ports return in grant order, one per cycle.
- Same-address write in cycle N then read in cycle N+1 (either port): the read returns the new data.
- Requests are level-based. A denied requester keeps req and its payload stable; the arbiter imposes no internal queueing.

Decomposition:
- Shared package holds:
  - state encoding ST_FREE/ST_BURST;
  - port-index constants PORT_C = 0, PORT_D = 1;
  - default MAX_WAIT/BURST_MAX values.
- Natural sub-module: m_arb_rdret, the 1-cycle read-return tracker. It registers grant port and read flag, then steers w_m_rdata and the rvalids.
- Grant logic, state register and counters stay in the top.

Test Plan:
- C-only, no D traffic:
  - Stimulus: C write addr 5 = 32'h1234, then C read addr 5.
  - Required: c_gnt both cycles, c_stall = 0, c_rvalid in cycle 3 with rdata 32'h1234.
- Contention:
  - Stimulus: c_req and d_req held high continuously, MAX_WAIT = 4.
  - Required: C granted for 4 cycles, D force-granted on the 5th with c_stall = 1, then wait_cnt = 0 and C resumes. The pattern repeats every 5 cycles.
- Locked burst:
  - Stimulus: D reads addr 0..9 with d_lock = 1, c_req high, BURST_MAX = 8.
  - Required: D granted 8 consecutive beats; C granted on the 9th cycle; d_rvalid for 8 cycles with the correct data.
- Burst early end:
  - Stimulus: d_lock drops on beat 3.
  - Required: beat 3 granted, state returns to ST_FREE, a pending C is granted on the next cycle.
- Reset mid-burst:
  - Stimulus: assert w_rst_n low asynchronously during beat 4 of a read burst.
  - Required: d_rvalid = 0 immediately, state ST_FREE, no rvalid after release, and the first post-reset C request is granted same-cycle.
- Alternating reads:
  - Stimulus: C read addr 1 (data 32'hA), then D read addr 2 (data 32'hB).
  - Required: c_rvalid with rdata A, then d_rvalid with rdata B on consecutive cycles; the other port's rvalid stays 0.
